// File: rtl/nibble_sub16_pkg.sv
// Shared types and defaults for the digit-serial 16-bit subtractor.
package nibble_sub16_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultStep  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Number of Step-bit digits needed to cover a Width-bit operand.
  function automatic int unsigned digit_count(int unsigned width, int unsigned step);
    return width / step;
  endfunction

endpackage

// File: rtl/nibble_sub16_if.sv
// Operand/result handshake bundle for nibble_sub16.
interface nibble_sub16_if
  import nibble_sub16_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] d;
  logic             bout;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
  );

endinterface

// File: rtl/nibble_sub16_digit_sub.sv
// Combinational Step-bit subtract slice: {c_o, r_o} = a_i + ~b_i + c_i.
module nibble_sub16_digit_sub #(
  parameter int unsigned Step = 4
) (
  input  logic [Step-1:0] a_i,
  input  logic [Step-1:0] b_i,
  input  logic            c_i,
  output logic [Step-1:0] r_o,
  output logic            c_o
);

  // Carry here is "no borrow": 1 means the digit did not underflow.
  assign {c_o, r_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{Step{1'b0}}, c_i};

endmodule

// File: rtl/nibble_sub16.sv
// Digit-serial unsigned subtractor: d = a - b - bin, one Step-bit digit per clock,
// LSB first, with valid/ready handshakes on operand and result sides.
module nibble_sub16
  import nibble_sub16_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth,
  parameter int unsigned Step  = DefaultStep
) (
  input  logic          clk_i,
  input  logic          rst_i,
  nibble_sub16_if.slave sub_io
);

  localparam int unsigned   NumDigits = digit_count(Width, Step);
  localparam int unsigned   CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [CntW-1:0] LastDigit = CntW'(NumDigits - 1);

  if ((Width % Step) != 0) begin : gen_width_check
    $error("nibble_sub16: Width must be a multiple of Step");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Width-1:0]  a_q, a_d;
  logic [Width-1:0]  b_q, b_d;
  logic [Width-1:0]  res_q, res_d;
  logic [Width-1:0]  d_q, d_d;
  logic              carry_q, carry_d;
  logic              bout_q, bout_d;

  logic [Step-1:0]   digit_r;
  logic              digit_c;

  // Single slice, time-multiplexed: operands shift right so the active digit is always at [Step-1:0].
  nibble_sub16_digit_sub #(
    .Step (Step)
  ) u_digit_sub (
    .a_i (a_q[Step-1:0]),
    .b_i (b_q[Step-1:0]),
    .c_i (carry_q),
    .r_o (digit_r),
    .c_o (digit_c)
  );

  // Next-state logic: operand capture, digit stepping and result publication.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    carry_d = carry_q;
    bout_d  = bout_q;

    unique case (state_q)
      StIdle: begin
        if (sub_io.in_valid) begin
          a_d     = sub_io.a;
          b_d     = sub_io.b;
          // a - b - bin == a + ~b + ~bin
          carry_d = ~sub_io.bin;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        a_d     = a_q >> Step;
        b_d     = b_q >> Step;
        carry_d = digit_c;
        for (int unsigned k = 0; k < NumDigits; k++) begin
          if (cnt_q == CntW'(k)) begin
            res_d[k*Step +: Step] = digit_r;
          end
        end
        if (cnt_q == LastDigit) begin
          cnt_d   = '0;
          state_d = StDone;
          d_d     = res_d;
          bout_d  = ~digit_c;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (sub_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
    end
  end

  assign sub_io.in_ready  = (state_q == StIdle);
  assign sub_io.out_valid = (state_q == StDone);
  assign sub_io.d         = d_q;
  assign sub_io.bout      = bout_q;

endmodule

// File: tb/tb_nibble_sub16.sv
// Self-checking bench for nibble_sub16: directed vectors plus a randomised
// handshake run against a queue of expected results.
module tb_nibble_sub16;

  logic clk;
  logic rst;

  int checks;
  int failures;

  nibble_sub16_if #(.Width(16)) sub_if ();

  nibble_sub16 #(
    .Width (16),
    .Step  (4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .sub_io (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one operand set while idle and wait for the result; reports edges to out_valid.
  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output int lat);
    sub_if.in_valid = 1'b1;
    sub_if.a        = a;
    sub_if.b        = b;
    sub_if.bin      = bin;
    @(negedge clk);
    sub_if.in_valid = 1'b0;
    sub_if.a        = 16'hxxxx;
    sub_if.b        = 16'hxxxx;
    sub_if.bin      = 1'bx;
    check_eq("busy_in_ready", 32'(sub_if.in_ready), 32'd0);
    lat = 0;
    while (!sub_if.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Check the pending result, then complete the handshake.
  task automatic take_result(input string tag, input logic [15:0] exp_d, input logic exp_bout);
    check_eq({tag, "_valid"}, 32'(sub_if.out_valid), 32'd1);
    check_eq({tag, "_d"}, 32'(sub_if.d), 32'(exp_d));
    check_eq({tag, "_bout"}, 32'(sub_if.bout), 32'(exp_bout));
    sub_if.out_ready = 1'b1;
    @(negedge clk);
    sub_if.out_ready = 1'b0;
    check_eq({tag, "_drop"}, 32'(sub_if.out_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(sub_if.in_ready), 32'd1);
  endtask

  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  int          lat;
  int          accepted;
  int          completed;
  int          stray;
  logic [15:0] ra, rb;
  logic        rbin;

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    sub_if.in_valid  = 1'b0;
    sub_if.out_ready = 1'b0;
    sub_if.a         = '0;
    sub_if.b         = '0;
    sub_if.bin       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_out_valid", 32'(sub_if.out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(sub_if.in_ready), 32'd1);
    check_eq("rst_d", 32'(sub_if.d), 32'h0);
    check_eq("rst_bout", 32'(sub_if.bout), 32'd0);

    send_op(16'h0000, 16'h0001, 1'b0, lat);
    check_eq("lat_0m1", 32'(lat), 32'd4);
    take_result("0m1", 16'hFFFF, 1'b1);

    send_op(16'hFFFF, 16'hFFFF, 1'b1, lat);
    check_eq("lat_fmf", 32'(lat), 32'd4);
    take_result("fmf", 16'hFFFF, 1'b1);

    send_op(16'h0004, 16'h0002, 1'b1, lat);
    take_result("4m2", 16'h0001, 1'b0);

    // Backpressure: result must hold while out_ready stays low.
    send_op(16'hAAAA, 16'h5555, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", 32'(sub_if.out_valid), 32'd1);
      check_eq("bp_d", 32'(sub_if.d), 32'h5555);
      check_eq("bp_in_ready", 32'(sub_if.in_ready), 32'd0);
      @(negedge clk);
    end
    take_result("bp", 16'h5555, 1'b0);

    // Reset two digits into a calculation.
    sub_if.in_valid = 1'b1;
    sub_if.a        = 16'hFFFF;
    sub_if.b        = 16'h0001;
    sub_if.bin      = 1'b0;
    @(negedge clk);
    sub_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("calc_d_hold", 32'(sub_if.d), 32'h5555);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(sub_if.out_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(sub_if.in_ready), 32'd1);
    check_eq("mid_rst_d", 32'(sub_if.d), 32'h0);
    check_eq("mid_rst_bout", 32'(sub_if.bout), 32'd0);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sub_if.out_valid) stray++;
    end
    check_eq("mid_rst_no_pulse", 32'(stray), 32'd0);
    send_op(16'h1234, 16'h0234, 1'b0, lat);
    check_eq("lat_1234", 32'(lat), 32'd4);
    take_result("1234", 16'h1000, 1'b0);

    // Random operands with random handshake gaps.
    accepted  = 0;
    completed = 0;
    for (int cyc = 0; cyc < 40000 && completed < 1000; cyc++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      sub_if.in_valid  = (accepted < 1000) && ($urandom_range(9, 0) < 7);
      sub_if.a         = ra;
      sub_if.b         = rb;
      sub_if.bin       = rbin;
      sub_if.out_ready = ($urandom_range(9, 0) < 6);
      #1;
      // Handshake signals are stable until the next rising edge.
      if (sub_if.in_valid && sub_if.in_ready) begin
        exp_v[15:0] = ra - rb - 16'(rbin);
        exp_v[16]   = (17'(ra) < 17'(rb) + 17'(rbin));
        exp_q.push_back(exp_v);
        accepted++;
      end
      if (sub_if.out_valid && sub_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rand_spurious", 32'd1, 32'd0);
        end else begin
          check_eq("rand_result", 32'({sub_if.bout, sub_if.d}), 32'(exp_q.pop_front()));
        end
        completed++;
      end
      @(negedge clk);
    end
    sub_if.in_valid  = 1'b0;
    sub_if.out_ready = 1'b0;
    check_eq("rand_completed", 32'(completed), 32'd1000);
    check_eq("rand_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
